// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory word port between I and D cache refill,
//                    sequencing each granted line as LINE_WORDS word beats.
// Revision 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int LINE_WORDS = 4
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_wnext,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int              CW        = $clog2(LINE_WORDS);
    localparam logic [31:0]     LINE_MASK = 32'(LINE_WORDS * 4 - 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(LINE_WORDS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_I_RD = 2'd1;
    localparam logic [1:0] ST_D_RD = 2'd2;
    localparam logic [1:0] ST_D_WR = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [31:0]   base_q, base_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;   // 1 = D side won last

    logic beat_done;
    logic line_end;
    logic grant_dside;

    assign beat_done   = mem_req & mem_ack;
    assign line_end    = beat_done & (cnt_q == CNT_LAST);
    // D wins when alone, or when both ask and I won last time.
    assign grant_dside = d_req & (~i_req | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        if (state_q == ST_IDLE) begin
            if (grant_dside) begin
                state_d      = d_we ? ST_D_WR : ST_D_RD;
                base_d       = d_addr & ~LINE_MASK;
                cnt_d        = '0;
                last_grant_d = 1'b1;
            end else if (i_req) begin
                state_d      = ST_I_RD;
                base_d       = i_addr & ~LINE_MASK;
                cnt_d        = '0;
                last_grant_d = 1'b0;
            end
        end else if (beat_done) begin
            cnt_d = cnt_q + CW'(1);
            if (line_end) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign mem_req   = (state_q != ST_IDLE);
    assign mem_we    = (state_q == ST_D_WR);
    // base is line aligned, so the beat offset never carries out of the line.
    assign mem_addr  = base_q + {{(30 - CW){1'b0}}, cnt_q, 2'b00};
    assign mem_wdata = d_wdata;

    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign i_rvalid  = beat_done & (state_q == ST_I_RD);
    assign d_rvalid  = beat_done & (state_q == ST_D_RD);
    assign d_wnext   = beat_done & (state_q == ST_D_WR);
    assign i_done    = line_end  & (state_q == ST_I_RD);
    assign d_done    = line_end  & (state_q != ST_I_RD);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and burst sequencer sharing the single main-memory word port between the instruction-cache refill path and the data-cache refill/writeback path of the RV32 pipeline core. It sits between the two cache miss controllers (whose miss flags feed the hazard unit's ICacheMiss/DCacheMiss stall inputs) and the external memory. It grants one requester at a time, then sequences a whole cache line, LINE_WORDS words long, as consecutive word beats.

## Interface
- LINE_WORDS, 4, words per cache line; power of two, ≥2
- CPU_CLK  in  1  core clock; all logic is clocked on its rising edge
- CPU_RST  in  1  reset; synchronous, active-low (0 = reset)
- i_req  in  1  I-side line read request; held high until i_done
- i_addr  in  32  I-side line address; sampled at grant
- i_rdata  out  32  read word to I-side; equal to mem_rdata
- i_rvalid  out  1  i_rdata valid this cycle
- i_done  out  1  last I-side beat completes this cycle
- d_req  in  1  D-side line request; held high until d_done
- d_we  in  1  1 = line writeback, 0 = line read; sampled at grant
- d_addr  in  32  D-side line address; sampled at grant
- d_wdata  in  32  current writeback word
- d_wnext  out  1  d_wdata consumed this cycle; requester advances to the next word
- d_rdata  out  32  read word to D-side; equal to mem_rdata
- d_rvalid  out  1  d_rdata valid this cycle
- d_done  out  1  last D-side beat completes this cycle
- mem_req  out  1  memory beat request
- mem_we  out  1  beat is a write
- mem_addr  out  32  word address of the beat
- mem_wdata  out  32  write data; equal to d_wdata
- mem_rdata  in  32  read data; valid when mem_ack=1
- mem_ack  in  1  beat completes this cycle

## Operation
- Four states: IDLE, I_RD, D_RD, D_WR.
- Registers: state, base (32), cnt (log2 LINE_WORDS bits), last_grant (1 bit, I or D).
- IDLE behaviour:
  - Only i_req high: go to I_RD.
  - Only d_req high: go to D_RD if d_we=0, D_WR if d_we=1.
  - Both high: grant the side opposite last_grant.
  - On grant: base ← granted address with bits [log2(LINE_WORDS)+1:0] cleared; cnt ← 0; last_grant ← granted side.
- Derived signals:
  - mem_req = (state≠IDLE).
  - mem_we = (state==D_WR).
  - mem_addr = base + (cnt<<2). No carry leaves the line field, because base is aligned.
- Beat completes when mem_req & mem_ack. On completion:
  - cnt increments.
  - I_RD: i_rvalid=1. D_RD: d_rvalid=1. D_WR: d_wnext=1.
  - If cnt==LINE_WORDS-1, the matching *_done=1 in the same cycle and state ← IDLE.
- mem_ack while mem_req=0 is ignored.
- rvalid, wnext and done are combinational from state, cnt and mem_ack. They are 0 in IDLE.
- Requests are not preempted; a granted line always runs to completion.
- Requester protocol: drop req on the edge after its done. A req still high in the IDLE cycle that follows is treated as a new request.

## Timing
- Reset (CPU_RST=0 at an edge) is effective the next cycle: state=IDLE, cnt=0, base=0, last_grant=I, mem_req=0, and every valid/done/wnext output is 0.
- Reset mid-burst aborts the burst; no done is issued.
- Because last_grant resets to I, D wins the first simultaneous request.
- Grant latency: req sampled high in IDLE at edge t → mem_req high from cycle t+1.
- A line with zero wait states takes LINE_WORDS cycles plus one IDLE cycle. Minimum turnaround between lines is 1 IDLE cycle.
- Each beat holds mem_addr, mem_we and mem_wdata stable until mem_ack; wait states are unbounded.
- i_rdata and d_rdata are mem_rdata passed straight through; they are meaningful only while the matching rvalid is high.

## Test plan
- Single I refill, LINE_WORDS=4, i_addr=0x0000_104C, mem_ack always 1 → mem_addr 0x1040, 0x1044, 0x1048, 0x104C on consecutive cycles, 4 i_rvalid pulses, i_done on the 4th, mem_req low on the next cycle.
- D writeback, d_addr=0x2000, d_we=1, wdata words A0..A3, mem_ack held low 2 cycles per beat → mem_we=1 throughout; each word stays on mem_wdata until its ack; 4 d_wnext pulses; d_done on the last beat.
- i_req and d_req (read) rise in the same cycle after reset, both re-requesting after done → order D, I, D, I (strict alternation); no two grants to one side while the other waits.
- Reset asserted during the 3rd beat of an I refill → next cycle mem_req=0, i_done never pulses; a later i_req restarts at word 0 of the line.
- mem_ack=1 while IDLE, with no req → no rvalid, wnext or done, and state stays IDLE.
- D read at d_addr=0xFFFF_FFF0 → beats at 0xFFFF_FFF0..0xFFFF_FFFC, with no address wrap into the next line.
